// File: rtl/mem_seq_if.sv
// Requester and memory-block signal bundle for mem_seq.
//
// Two requester ports (a_*: fetch unit, b_*: execute/DMA) carry byte/word
// read/write requests and get a one-cycle ack with read data. The memory
// side carries the MDR value (mem_out) in, and the shared bus value plus the
// MAR/MDR/RAM control strobes out.
//
// Modports:
//   slave  - the sequencer (mem_seq)
//   master - whatever drives requests and models the memory block
interface mem_seq_if;
  // Port A
  logic        a_req;
  logic        a_we;
  logic        a_word;
  logic [15:0] a_addr;
  logic [15:0] a_wdata;
  logic        a_ack;
  logic [15:0] a_rdata;
  // Port B
  logic        b_req;
  logic        b_we;
  logic        b_word;
  logic [15:0] b_addr;
  logic [15:0] b_wdata;
  logic        b_ack;
  logic [15:0] b_rdata;
  // Memory block
  logic [15:0] mem_out;
  logic [15:0] bus_out;
  logic        bus_en;
  logic        mar_load;
  logic        mdr_load_bus;
  logic        mdr_load_low;
  logic        mdr_load_high;
  logic        ram_write;
  logic        busy;

  modport slave (
    input  a_req, a_we, a_word, a_addr, a_wdata,
    output a_ack, a_rdata,
    input  b_req, b_we, b_word, b_addr, b_wdata,
    output b_ack, b_rdata,
    input  mem_out,
    output bus_out, bus_en, mar_load, mdr_load_bus, mdr_load_low, mdr_load_high,
    output ram_write, busy
  );

  modport master (
    output a_req, a_we, a_word, a_addr, a_wdata,
    input  a_ack, a_rdata,
    output b_req, b_we, b_word, b_addr, b_wdata,
    input  b_ack, b_rdata,
    output mem_out,
    input  bus_out, bus_en, mar_load, mdr_load_bus, mdr_load_low, mdr_load_high,
    input  ram_write, busy
  );
endinterface

// File: rtl/mem_seq.sv
// Memory sequencer and two-port arbiter for the byte-wide SAP-2 memory block.
//
// Accepts byte or 16-bit little-endian word read/write requests from two
// requesters, walks the MAR/MDR/RAM strobes one step per cycle, and returns
// read data alongside a one-cycle ack to the granted port.
//
// Parameters:
//   FIXED_PRIO - 0: round-robin on ties; 1: port A always wins ties
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous, active-high reset
//   sif  - mem_seq_if.slave: requester ports A/B, mem_out in, bus/strobes out
//
// All outputs are decoded from registered state (Moore). mem_out is only
// consumed in StDone, where the MDR was loaded on the edge entering it.
module mem_seq #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input logic      clk,
  input logic      rst,
  mem_seq_if.slave sif
);

  typedef enum logic [3:0] {
    StIdle,
    StMar0,
    StRd0,
    StWd0,
    StWr0,
    StMar1,
    StRd1,
    StWd1,
    StWr1,
    StDone
  } state_e;

  state_e      state_q, state_d;
  // Port encoding for port_q / last_grant_q: 0 = A, 1 = B
  logic        port_q, port_d;
  logic        last_grant_q, last_grant_d;
  logic        we_q, we_d;
  logic        word_q, word_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;

  logic        grant_b;
  logic        any_req;

  logic [15:0] bus_out;
  logic        bus_en;
  logic        mar_load;
  logic        mdr_load_bus;
  logic        mdr_load_low;
  logic        mdr_load_high;
  logic        ram_write;
  logic        ack;
  logic [15:0] rdata;

  // Arbitration
  assign any_req = sif.a_req | sif.b_req;

  always_comb begin
    grant_b = 1'b0;
    if (sif.a_req && sif.b_req) begin
      // On a tie, round-robin hands the grant to whoever did not have it last.
      grant_b = FIXED_PRIO ? 1'b0 : ~last_grant_q;
    end else begin
      grant_b = sif.b_req;
    end
  end

  // Next state and request latch
  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    word_d       = word_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (any_req) begin
          state_d      = StMar0;
          port_d       = grant_b;
          last_grant_d = grant_b;
          we_d         = grant_b ? sif.b_we    : sif.a_we;
          word_d       = grant_b ? sif.b_word  : sif.a_word;
          addr_d       = grant_b ? sif.b_addr  : sif.a_addr;
          wdata_d      = grant_b ? sif.b_wdata : sif.a_wdata;
        end
      end
      StMar0:  state_d = we_q ? StWd0 : StRd0;
      StRd0:   state_d = word_q ? StMar1 : StDone;
      StWd0:   state_d = StWr0;
      StWr0:   state_d = word_q ? StMar1 : StDone;
      StMar1:  state_d = we_q ? StWd1 : StRd1;
      StRd1:   state_d = StDone;
      StWd1:   state_d = StWr1;
      StWr1:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      port_q       <= 1'b0;
      last_grant_q <= 1'b1;  // B, so A wins the first tie
      we_q         <= 1'b0;
      word_q       <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      word_q       <= word_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  // Output decode: at most one strobe per state
  always_comb begin
    bus_out       = '0;
    bus_en        = 1'b0;
    mar_load      = 1'b0;
    mdr_load_bus  = 1'b0;
    mdr_load_low  = 1'b0;
    mdr_load_high = 1'b0;
    ram_write     = 1'b0;
    ack           = 1'b0;

    unique case (state_q)
      StMar0: begin
        bus_out  = addr_q;
        bus_en   = 1'b1;
        mar_load = 1'b1;
      end
      StRd0: mdr_load_low = 1'b1;
      StWd0: begin
        bus_out      = wdata_q;
        bus_en       = 1'b1;
        mdr_load_bus = 1'b1;
      end
      StWr0: ram_write = 1'b1;
      StMar1: begin
        bus_out  = addr_q + 16'd1;  // wraps 0xFFFF -> 0x0000
        bus_en   = 1'b1;
        mar_load = 1'b1;
      end
      StRd1: mdr_load_high = 1'b1;
      StWd1: begin
        bus_out      = {8'h00, wdata_q[15:8]};
        bus_en       = 1'b1;
        mdr_load_bus = 1'b1;
      end
      StWr1:   ram_write = 1'b1;
      StDone:  ack = 1'b1;
      default: ;
    endcase
  end

  // Byte reads drop whatever stale high byte the MDR still holds.
  always_comb begin
    rdata = '0;
    if (ack && !we_q) begin
      rdata = word_q ? sif.mem_out : {8'h00, sif.mem_out[7:0]};
    end
  end

  assign sif.a_ack         = ack & ~port_q;
  assign sif.b_ack         = ack & port_q;
  assign sif.a_rdata       = port_q ? 16'h0000 : rdata;
  assign sif.b_rdata       = port_q ? rdata : 16'h0000;
  assign sif.bus_out       = bus_out;
  assign sif.bus_en        = bus_en;
  assign sif.mar_load      = mar_load;
  assign sif.mdr_load_bus  = mdr_load_bus;
  assign sif.mdr_load_low  = mdr_load_low;
  assign sif.mdr_load_high = mdr_load_high;
  assign sif.ram_write     = ram_write;
  assign sif.busy          = (state_q != StIdle);

endmodule

// File: tb/tb_mem_seq.sv
// Testbench for mem_seq: two instances (round-robin and fixed priority), a
// behavioural MAR/MDR/RAM model on the round-robin instance, directed tests.
module tb_mem_seq;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_seq_if m0 ();
  mem_seq_if m1 ();

  mem_seq #(.FIXED_PRIO(1'b0)) dut0 (.clk(clk), .rst(rst), .sif(m0));
  mem_seq #(.FIXED_PRIO(1'b1)) dut1 (.clk(clk), .rst(rst), .sif(m1));

  int errors = 0;
  int checks = 0;
  int cycle  = 0;

  always @(posedge clk) cycle <= cycle + 1;

  // Memory block model for dut0
  logic [7:0]  ram [0:65535];
  logic [15:0] mar = 16'h0000;
  logic [15:0] mdr = 16'h0000;
  logic        poke_en = 1'b0;
  logic [15:0] poke_addr = 16'h0000;
  logic [7:0]  poke_data = 8'h00;
  logic        preload_en = 1'b0;
  logic [7:0]  preload_hi = 8'h00;

  always @(posedge clk) begin
    if (m0.mar_load)      mar <= m0.bus_out;
    if (m0.mdr_load_bus)  mdr <= m0.bus_out;
    if (m0.mdr_load_low)  mdr[7:0] <= ram[mar];
    if (m0.mdr_load_high) mdr[15:8] <= ram[mar];
    if (m0.ram_write)     ram[mar] <= mdr[7:0];
    if (poke_en)          ram[poke_addr] <= poke_data;
    if (preload_en)       mdr[15:8] <= preload_hi;
  end

  assign m0.mem_out = mdr;
  assign m1.mem_out = 16'h0000;

  logic [15:0] mar_seen [2];
  int          mar_n;

  task automatic poke(input logic [15:0] addr, input logic [7:0] data);
    @(negedge clk);
    poke_en = 1'b1; poke_addr = addr; poke_data = data;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic preload_mdr_hi(input logic [7:0] val);
    @(negedge clk);
    preload_en = 1'b1; preload_hi = val;
    @(negedge clk);
    preload_en = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One transaction on dut0. lat is the ack cycle relative to the grant edge
  // (-1 if no ack within the budget). With junk set, addr/wdata are
  // scrambled one cycle after grant.
  task automatic run_txn(input bit port, input bit we, input bit word,
                         input logic [15:0] addr, input logic [15:0] wdata, input bit junk,
                         output int lat, output logic [15:0] rdata, output bit other_ack);
    lat = -1; rdata = 16'h0000; other_ack = 1'b0; mar_n = 0;
    @(negedge clk);
    if (!port) begin
      m0.a_req = 1'b1; m0.a_we = we; m0.a_word = word; m0.a_addr = addr; m0.a_wdata = wdata;
    end else begin
      m0.b_req = 1'b1; m0.b_we = we; m0.b_word = word; m0.b_addr = addr; m0.b_wdata = wdata;
    end
    @(posedge clk);
    @(negedge clk);
    m0.a_req = 1'b0;
    m0.b_req = 1'b0;
    if (junk) begin
      if (!port) begin m0.a_addr = 16'h0BAD; m0.a_wdata = 16'h0000; end
      else       begin m0.b_addr = 16'h0BAD; m0.b_wdata = 16'h0000; end
    end
    for (int n = 0; n < 16; n++) begin
      if (n > 0) @(negedge clk);
      if (m0.mar_load && mar_n < 2) begin
        mar_seen[mar_n] = m0.bus_out;
        mar_n++;
      end
      if (port ? m0.b_ack : m0.a_ack) begin
        lat = n;
        rdata = port ? m0.b_rdata : m0.a_rdata;
        break;
      end
      if (port ? m0.a_ack : m0.b_ack) other_ack = 1'b1;
    end
  endtask

  // Wait for the next ack on either port of the chosen instance.
  task automatic wait_ack(input bit use_m1, output int port, output int at);
    port = -1; at = -1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (use_m1 ? m1.a_ack : m0.a_ack) begin port = 0; at = cycle; break; end
      if (use_m1 ? m1.b_ack : m0.b_ack) begin port = 1; at = cycle; break; end
    end
  endtask

  task automatic test_reset();
    logic [8:0] ctl;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ctl = {m0.busy, m0.bus_en, m0.mar_load, m0.mdr_load_bus, m0.mdr_load_low,
           m0.mdr_load_high, m0.ram_write, m0.a_ack, m0.b_ack};
    checks++;
    if (ctl !== 9'h000) begin
      errors++; $display("FAIL reset_ctl: got %b expected %b", ctl, 9'h000);
    end
    checks++;
    if (m0.bus_out !== 16'h0000) begin
      errors++; $display("FAIL reset_bus_out: got %h expected 0000", m0.bus_out);
    end
    checks++;
    if ({m0.a_rdata, m0.b_rdata} !== 32'h0) begin
      errors++; $display("FAIL reset_rdata: got %h expected 0", {m0.a_rdata, m0.b_rdata});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (m0.busy !== 1'b0) begin
      errors++; $display("FAIL idle_busy: got %b expected 0", m0.busy);
    end
  endtask

  task automatic test_word_rw();
    int lat; logic [15:0] rd; bit oth;
    run_txn(1'b0, 1'b1, 1'b1, 16'h1234, 16'hBEEF, 1'b0, lat, rd, oth);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL ww_latency: got %0d expected 6", lat); end
    checks++;
    if (rd !== 16'h0000) begin errors++; $display("FAIL ww_rdata: got %h expected 0000", rd); end
    checks++;
    if (ram[16'h1234] !== 8'hEF) begin
      errors++; $display("FAIL ww_ram_lo: got %h expected EF", ram[16'h1234]);
    end
    checks++;
    if (ram[16'h1235] !== 8'hBE) begin
      errors++; $display("FAIL ww_ram_hi: got %h expected BE", ram[16'h1235]);
    end
    run_txn(1'b0, 1'b0, 1'b1, 16'h1234, 16'h0000, 1'b0, lat, rd, oth);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL wr_latency: got %0d expected 4", lat); end
    checks++;
    if (rd !== 16'hBEEF) begin errors++; $display("FAIL wr_rdata: got %h expected BEEF", rd); end
  endtask

  task automatic test_byte_b();
    int lat; logic [15:0] rd; bit oth;
    poke(16'h0010, 8'h5C);
    preload_mdr_hi(8'hAA);
    run_txn(1'b1, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, lat, rd, oth);
    checks++;
    if (lat !== 2) begin errors++; $display("FAIL br_latency: got %0d expected 2", lat); end
    checks++;
    if (rd !== 16'h005C) begin errors++; $display("FAIL br_rdata: got %h expected 005C", rd); end
    checks++;
    if (oth !== 1'b0) begin errors++; $display("FAIL br_a_ack: got %b expected 0", oth); end
    poke(16'h0021, 8'h11);
    run_txn(1'b1, 1'b1, 1'b0, 16'h0020, 16'h3342, 1'b0, lat, rd, oth);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL bw_latency: got %0d expected 3", lat); end
    checks++;
    if (ram[16'h0020] !== 8'h42) begin
      errors++; $display("FAIL bw_ram: got %h expected 42", ram[16'h0020]);
    end
    checks++;
    if (ram[16'h0021] !== 8'h11) begin
      errors++; $display("FAIL bw_neighbour: got %h expected 11", ram[16'h0021]);
    end
  endtask

  task automatic test_wrap();
    int lat; logic [15:0] rd; bit oth;
    run_txn(1'b0, 1'b1, 1'b1, 16'hFFFF, 16'h1357, 1'b0, lat, rd, oth);
    checks++;
    if (lat !== 6) begin errors++; $display("FAIL wrap_latency: got %0d expected 6", lat); end
    checks++;
    if (mar_seen[0] !== 16'hFFFF) begin
      errors++; $display("FAIL wrap_mar0: got %h expected FFFF", mar_seen[0]);
    end
    checks++;
    if (mar_seen[1] !== 16'h0000) begin
      errors++; $display("FAIL wrap_mar1: got %h expected 0000", mar_seen[1]);
    end
    checks++;
    if (ram[16'hFFFF] !== 8'h57) begin
      errors++; $display("FAIL wrap_ram_lo: got %h expected 57", ram[16'hFFFF]);
    end
    checks++;
    if (ram[16'h0000] !== 8'h13) begin
      errors++; $display("FAIL wrap_ram_hi: got %h expected 13", ram[16'h0000]);
    end
  endtask

  task automatic test_round_robin();
    int p, at;
    int exp_p [4] = '{0, 1, 0, 1};
    do_reset();
    m0.a_we = 1'b0; m0.a_word = 1'b0; m0.a_addr = 16'h0010;
    m0.b_we = 1'b0; m0.b_word = 1'b0; m0.b_addr = 16'h0020;
    m0.a_req = 1'b1; m0.b_req = 1'b1;
    for (int g = 0; g < 4; g++) begin
      wait_ack(1'b0, p, at);
      if (g == 3) begin m0.a_req = 1'b0; m0.b_req = 1'b0; end
      checks++;
      if (p !== exp_p[g]) begin
        errors++; $display("FAIL rr_grant%0d: got port %0d expected port %0d", g, p, exp_p[g]);
      end
    end
    m0.a_req = 1'b0; m0.b_req = 1'b0;
  endtask

  task automatic test_fixed_prio();
    int p, at;
    do_reset();
    m1.a_we = 1'b0; m1.a_word = 1'b0; m1.a_addr = 16'h0010;
    m1.b_we = 1'b0; m1.b_word = 1'b0; m1.b_addr = 16'h0020;
    m1.a_req = 1'b1; m1.b_req = 1'b1;
    for (int g = 0; g < 3; g++) begin
      wait_ack(1'b1, p, at);
      if (g == 2) begin m1.a_req = 1'b0; m1.b_req = 1'b0; end
      checks++;
      if (p !== 0) begin
        errors++; $display("FAIL prio_grant%0d: got port %0d expected port 0", g, p);
      end
    end
    m1.a_req = 1'b0; m1.b_req = 1'b0;
  endtask

  task automatic test_back_to_back();
    int p [3];
    int at [3];
    do_reset();
    m0.a_we = 1'b0; m0.a_word = 1'b1; m0.a_addr = 16'h1234;
    m0.b_we = 1'b0; m0.b_word = 1'b1; m0.b_addr = 16'h1234;
    m0.a_req = 1'b1; m0.b_req = 1'b1;
    for (int g = 0; g < 3; g++) begin
      wait_ack(1'b0, p[g], at[g]);
      if (g == 2) begin m0.a_req = 1'b0; m0.b_req = 1'b0; end
    end
    checks++;
    if ({p[0], p[1], p[2]} !== {32'd0, 32'd1, 32'd0}) begin
      errors++; $display("FAIL b2b_ports: got %0d,%0d,%0d expected 0,1,0", p[0], p[1], p[2]);
    end
    checks++;
    if (at[1] - at[0] !== 6 || at[2] - at[1] !== 6) begin
      errors++;
      $display("FAIL b2b_spacing: got %0d,%0d expected 6,6", at[1] - at[0], at[2] - at[1]);
    end
  endtask

  task automatic test_reset_mid();
    int lat; logic [15:0] rd; bit oth; bit seen; logic [8:0] ctl;
    poke(16'h0200, 8'h00);
    poke(16'h0201, 8'h77);
    @(negedge clk);
    m0.a_req = 1'b1; m0.a_we = 1'b1; m0.a_word = 1'b1;
    m0.a_addr = 16'h0200; m0.a_wdata = 16'hCAFE;
    @(posedge clk);
    @(negedge clk);
    m0.a_req = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (m0.ram_write !== 1'b1) begin
      errors++; $display("FAIL rm_in_wr0: got %b expected 1", m0.ram_write);
    end
    // Reset lands right after the edge that commits the WR0 byte.
    @(posedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    ctl = {m0.busy, m0.bus_en, m0.mar_load, m0.mdr_load_bus, m0.mdr_load_low,
           m0.mdr_load_high, m0.ram_write, m0.a_ack, m0.b_ack};
    checks++;
    if (ctl !== 9'h000 || m0.bus_out !== 16'h0000 || m0.a_rdata !== 16'h0000) begin
      errors++; $display("FAIL rm_outputs: got %b/%h/%h expected 0", ctl, m0.bus_out, m0.a_rdata);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (m0.a_ack || m0.b_ack) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL rm_no_ack: got %b expected 0", seen); end
    checks++;
    if (ram[16'h0200] !== 8'hFE) begin
      errors++; $display("FAIL rm_ram_lo: got %h expected FE", ram[16'h0200]);
    end
    checks++;
    if (ram[16'h0201] !== 8'h77) begin
      errors++; $display("FAIL rm_ram_hi: got %h expected 77", ram[16'h0201]);
    end
    run_txn(1'b0, 1'b0, 1'b0, 16'h0200, 16'h0000, 1'b0, lat, rd, oth);
    checks++;
    if (lat !== 2 || rd !== 16'h00FE) begin
      errors++; $display("FAIL rm_after: got lat %0d data %h expected lat 2 data 00FE", lat, rd);
    end
  endtask

  task automatic test_drop_req();
    int lat; logic [15:0] rd; bit oth;
    poke(16'h0300, 8'h3C);
    poke(16'h0301, 8'h5A);
    poke(16'h0BAD, 8'h00);
    run_txn(1'b0, 1'b0, 1'b1, 16'h0300, 16'h0000, 1'b1, lat, rd, oth);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL drop_rd_latency: got %0d expected 4", lat); end
    checks++;
    if (rd !== 16'h5A3C) begin errors++; $display("FAIL drop_rd_data: got %h expected 5A3C", rd); end
    run_txn(1'b1, 1'b1, 1'b0, 16'h0310, 16'h0099, 1'b1, lat, rd, oth);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL drop_wr_latency: got %0d expected 3", lat); end
    checks++;
    if (ram[16'h0310] !== 8'h99) begin
      errors++; $display("FAIL drop_wr_ram: got %h expected 99", ram[16'h0310]);
    end
    checks++;
    if (ram[16'h0BAD] !== 8'h00) begin
      errors++; $display("FAIL drop_wr_junk: got %h expected 00", ram[16'h0BAD]);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0.a_req = 1'b0; m0.a_we = 1'b0; m0.a_word = 1'b0; m0.a_addr = '0; m0.a_wdata = '0;
    m0.b_req = 1'b0; m0.b_we = 1'b0; m0.b_word = 1'b0; m0.b_addr = '0; m0.b_wdata = '0;
    m1.a_req = 1'b0; m1.a_we = 1'b0; m1.a_word = 1'b0; m1.a_addr = '0; m1.a_wdata = '0;
    m1.b_req = 1'b0; m1.b_we = 1'b0; m1.b_word = 1'b0; m1.b_addr = '0; m1.b_wdata = '0;
    test_reset();
    test_word_rw();
    test_byte_b();
    test_wrap();
    test_round_robin();
    test_fixed_prio();
    test_back_to_back();
    test_reset_mid();
    test_drop_req();
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
